fetch_issue_queue: RTL

- Small instruction buffer directly downstream of the fetch unit.
- Captures instruction/PC pairs when fetch reports valid and hands them to decode over a valid/ready handshake, so a decode stall no longer loses fetched words.
- Discards all buffered entries on a control-flow redirect (JAL, JALR, taken branch, interrupt).
- Per-core instance, same parameter set as the fetch path.

---
 rtl/fetch_issue_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: instruction/PC buffer between fetch and decode.
// Ports: clock, reset (async, high), flush; in_valid/in_instruction/in_PC
// with in_ready from fetch; out_valid/out_instruction/out_PC with
// out_ready to decode; count occupancy; stall_cycles/flushed_entries
// statistics; report prints state. Statistics exist only when
// FETCH_QUEUE_STATS_EN is defined, otherwise they read as 0.
module fetch_issue_queue #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH_BITS   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_instruction,
    input  logic [ADDRESS_BITS-1:0] in_PC,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_instruction,
    output logic [ADDRESS_BITS-1:0] out_PC,
    input  logic                    out_ready,
    output logic [DEPTH_BITS:0]     count,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flushed_entries,
    input  logic                    report
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int PW    = DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;
    localparam int EW    = DATA_WIDTH + ADDRESS_BITS;
    localparam logic [CW-1:0] FULL = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    always_comb begin
        in_ready        = (count_q != FULL);
        // Decode never sees a head entry during a redirect cycle.
        out_valid       = (count_q != '0) & ~flush;
        push            = in_valid & in_ready & ~flush;
        pop             = out_valid & out_ready;
        head            = mem_q[rd_ptr_q];
        out_instruction = '0;
        out_PC          = '0;
        if (out_valid) begin
            {out_instruction, out_PC} = head;
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_instruction, in_PC};
        end
    end

    assign count = count_q;

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flushed_q, flushed_d;
    logic [32:0] flushed_sum;

    always_comb begin
        stall_d     = stall_q;
        flushed_d   = flushed_q;
        flushed_sum = {1'b0, flushed_q} + 33'(count_q);
        if (in_valid & ~in_ready & ~flush & (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        // Saturate instead of wrapping on overflow.
        if (flush) begin
            flushed_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign stall_cycles    = stall_q;
    assign flushed_entries = flushed_q;
`else
    assign stall_cycles    = '0;
    assign flushed_entries = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (report) begin
`ifdef FETCH_QUEUE_STATS_EN
            $display("fiq core%0d cnt=%0d wr=%0d rd=%0d pc=%h ins=%h ir=%b ov=%b stall=%0d flushed=%0d",
                     CORE, count_q, wr_ptr_q, rd_ptr_q, out_PC,
                     out_instruction, in_ready, out_valid,
                     stall_cycles, flushed_entries);
`else
            $display("fiq core%0d cnt=%0d wr=%0d rd=%0d pc=%h ins=%h ir=%b ov=%b",
                     CORE, count_q, wr_ptr_q, rd_ptr_q, out_PC,
                     out_instruction, in_ready, out_valid);
`endif
        end
    end
`endif

endmodule
